gamepad_input_ctrl: RTL

GAMEPAD_INPUT_CTRL -- requirements
Module: gamepad_input_ctrl

---
 rtl/gamepad_input_ctrl_pkg.sv | 26 ++
 rtl/gamepad_input_ctrl_cycle_timer.sv | 25 ++
 rtl/gamepad_input_ctrl.sv | 109 ++++++++++
 3 files changed

// File: rtl/gamepad_input_ctrl_pkg.sv
// Shared definitions for the gamepad input controller: link state encoding
// and counter sizing helpers.
package gamepad_input_ctrl_pkg;

    localparam int unsigned LINK_W = 2;

    typedef enum logic [LINK_W-1:0] {
        HOLD   = 2'd0,
        BOOT   = 2'd1,
        ACTIVE = 2'd2,
        STALE  = 2'd3
    } link_state_t;

    function automatic int unsigned max3(input int unsigned a,
                                         input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/gamepad_input_ctrl_cycle_timer.sv
// Up-counter with synchronous clear and a loadable terminal value; one
// instance is shared by the hold, boot and frame timeouts.
module cycle_timer #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_clear,
    input  logic [WIDTH-1:0] i_term,
    output logic             o_tc
);

    logic [WIDTH-1:0] r_cnt;

    assign o_tc = (r_cnt == i_term);

    always_ff @(posedge i_clk) begin
        if (i_reset || i_clear) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + WIDTH'(1);
        end
    end

endmodule

// File: rtl/gamepad_input_ctrl.sv
// ESP32 link supervisor: sequences the ESP32 enable, tracks frame freshness
// and delivers the merged button state to the system.
module gamepad_input_ctrl
    import gamepad_input_ctrl_pkg::*;
#(
    parameter int unsigned PAD_BUTTONS          = 12,
    parameter int unsigned RESET_HOLD_CYCLES    = 1000000,
    parameter int unsigned BOOT_TIMEOUT_CYCLES  = 50000000,
    parameter int unsigned FRAME_TIMEOUT_CYCLES = 2000000,
    parameter int unsigned MERGE_BOARD          = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   user_reset,
    input  logic                   frame_valid,
    input  logic [PAD_BUTTONS-1:0] frame_data,
    input  logic [PAD_BUTTONS-1:0] board_btn,
    output logic                   esp32_en,
    output logic [PAD_BUTTONS-1:0] pad_btn,
    output logic [LINK_W-1:0]      link_state,
    output logic [7:0]             frame_count
);

    localparam int unsigned CNT_W = cnt_width(max3(RESET_HOLD_CYCLES,
                                                   BOOT_TIMEOUT_CYCLES,
                                                   FRAME_TIMEOUT_CYCLES));
    localparam logic [CNT_W-1:0] HOLD_TERM  = CNT_W'(RESET_HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] BOOT_TERM  = CNT_W'(BOOT_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] FRAME_TERM = CNT_W'(FRAME_TIMEOUT_CYCLES - 1);

    link_state_t            r_state;
    link_state_t            w_next_state;
    logic [PAD_BUTTONS-1:0] r_latch;
    logic [PAD_BUTTONS-1:0] w_latch_next;
    logic [PAD_BUTTONS-1:0] w_pad_next;
    logic [CNT_W-1:0]       w_term;
    logic                   w_tc;
    logic                   w_accept;
    logic                   w_clear;

    cycle_timer #(
        .WIDTH (CNT_W)
    ) u_timer (
        .i_clk   (clk),
        .i_reset (reset),
        .i_clear (w_clear),
        .i_term  (w_term),
        .o_tc    (w_tc)
    );

    assign esp32_en   = (r_state != HOLD);
    assign link_state = r_state;

    always_comb begin
        w_accept     = frame_valid && (r_state != HOLD) && !user_reset;
        w_next_state = r_state;
        w_term       = FRAME_TERM;

        case (r_state)
            HOLD: begin
                w_term = HOLD_TERM;
                if (w_tc) w_next_state = BOOT;
            end
            BOOT: begin
                w_term = BOOT_TERM;
                if (frame_valid)  w_next_state = ACTIVE;
                else if (w_tc)    w_next_state = STALE;
            end
            ACTIVE: begin
                if (!frame_valid && w_tc) w_next_state = STALE;
            end
            STALE: begin
                if (frame_valid) w_next_state = ACTIVE;
            end
            default: w_next_state = HOLD;
        endcase

        if (user_reset) w_next_state = HOLD;

        // STALE has no timeout of its own, so the counter idles at zero there.
        w_clear = user_reset || w_accept || w_tc || (r_state == STALE);

        w_latch_next = w_accept ? frame_data : r_latch;

        // pad_btn is registered from the next state so a frame shows up on
        // the very cycle the link reports ACTIVE.
        case (w_next_state)
            HOLD:    w_pad_next = '0;
            ACTIVE:  w_pad_next = (MERGE_BOARD != 0) ? (w_latch_next | board_btn)
                                                     : w_latch_next;
            default: w_pad_next = board_btn;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= HOLD;
            r_latch     <= '0;
            pad_btn     <= '0;
            frame_count <= '0;
        end else begin
            r_state <= w_next_state;
            r_latch <= w_latch_next;
            pad_btn <= w_pad_next;
            if (w_accept) frame_count <= frame_count + 8'd1;
        end
    end

endmodule
